// File: rtl/reg_rename_ctrl_if.sv
// Decoder / ROB / register-file bundle around the rename controller.
// master = controller side, slave = decoder/ROB/register-file side.
interface reg_rename_ctrl_if #(
    parameter int unsigned REG_W  = 5,
    parameter int unsigned ROB_W  = 4,
    parameter int unsigned DATA_W = 32
);
    logic              flush_in;
    logic              dec_valid;
    logic [REG_W-1:0]  dec_rd;
    logic [ROB_W-1:0]  dec_tag;
    logic              dec_ready;
    logic              cmt_valid;
    logic [REG_W-1:0]  cmt_rd;
    logic [ROB_W-1:0]  cmt_tag;
    logic [DATA_W-1:0] cmt_value;
    logic [REG_W-1:0]  rf_occ_reg;
    logic [ROB_W-1:0]  rf_occ_tag;
    logic [REG_W-1:0]  rf_set_reg;
    logic [ROB_W-1:0]  rf_set_tag;
    logic [DATA_W-1:0] rf_set_value;
    logic              rf_clr_en;
    logic [REG_W-1:0]  rf_clr_base;
    logic              sweeping;
    logic [15:0]       stall_cnt;

    modport master (
        input  flush_in, dec_valid, dec_rd, dec_tag,
        input  cmt_valid, cmt_rd, cmt_tag, cmt_value,
        output dec_ready,
        output rf_occ_reg, rf_occ_tag,
        output rf_set_reg, rf_set_tag, rf_set_value,
        output rf_clr_en, rf_clr_base,
        output sweeping, stall_cnt
    );

    modport slave (
        output flush_in, dec_valid, dec_rd, dec_tag,
        output cmt_valid, cmt_rd, cmt_tag, cmt_value,
        input  dec_ready,
        input  rf_occ_reg, rf_occ_tag,
        input  rf_set_reg, rf_set_tag, rf_set_value,
        input  rf_clr_en, rf_clr_base,
        input  sweeping, stall_cnt
    );
endinterface

// File: rtl/reg_rename_ctrl.sv
// Register-file update sequencer: forwards renames (occupy) and commits
// (set value), and sweeps the tag array clear in chunks after reset/flush.
module reg_rename_ctrl #(
    parameter int unsigned REG_COUNT = 32,
    parameter int unsigned REG_W     = 5,
    parameter int unsigned ROB_W     = 4,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned CLR_CHUNK = 4
) (
    input  logic                clk,
    input  logic                rst,
    reg_rename_ctrl_if.master   bus
);
    typedef enum logic {S_CLEAR, S_IDLE} state_t;

    localparam logic [REG_W-1:0] CHUNK     = REG_W'(CLR_CHUNK);
    localparam logic [REG_W-1:0] LAST_BASE = REG_W'(REG_COUNT - CLR_CHUNK);

    state_t            state_q, state_d;
    logic [REG_W-1:0]  base_q, base_d;
    logic              ready_q, ready_d;
    logic [REG_W-1:0]  occ_reg_q, occ_reg_d;
    logic [ROB_W-1:0]  occ_tag_q, occ_tag_d;
    logic [REG_W-1:0]  set_reg_q, set_reg_d;
    logic [ROB_W-1:0]  set_tag_q, set_tag_d;
    logic [DATA_W-1:0] set_val_q, set_val_d;
    logic              clr_en_q, clr_en_d;
    logic [REG_W-1:0]  clr_base_q, clr_base_d;
    logic [15:0]       stall_q, stall_d;
    logic              dec_ready;

    // A flush kills the same-cycle rename.
    assign dec_ready = ready_q && !bus.flush_in;

    // Sweep FSM: next state, sweep pointer and clear-port outputs.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        clr_en_d   = 1'b0;
        clr_base_d = '0;
        case (state_q)
            S_CLEAR: begin
                clr_en_d = 1'b1;
                if (bus.flush_in) begin
                    // Restart: issue chunk 0 now so the sweep stays full length.
                    clr_base_d = '0;
                    base_d     = CHUNK;
                end else begin
                    clr_base_d = base_q;
                    base_d     = base_q + CHUNK;
                    if (base_q == LAST_BASE) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_IDLE: begin
                if (bus.flush_in) begin
                    state_d = S_CLEAR;
                    base_d  = '0;
                end
            end
            default: begin
                state_d = S_CLEAR;
                base_d  = '0;
            end
        endcase
        ready_d = (state_d == S_IDLE);
    end

    // Rename/commit forwarding and the stall counter.
    always_comb begin
        occ_reg_d = '0;
        occ_tag_d = '0;
        set_reg_d = '0;
        set_tag_d = '0;
        set_val_d = '0;
        stall_d   = stall_q;
        if (bus.dec_valid && dec_ready && (bus.dec_rd != '0)) begin
            occ_reg_d = bus.dec_rd;
            occ_tag_d = bus.dec_tag;
        end
        if (bus.cmt_valid && (bus.cmt_rd != '0)) begin
            set_reg_d = bus.cmt_rd;
            set_tag_d = bus.cmt_tag;
            set_val_d = bus.cmt_value;
        end
        if (bus.dec_valid && !dec_ready && (stall_q != '1)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_CLEAR;
            base_q     <= '0;
            ready_q    <= 1'b0;
            occ_reg_q  <= '0;
            occ_tag_q  <= '0;
            set_reg_q  <= '0;
            set_tag_q  <= '0;
            set_val_q  <= '0;
            clr_en_q   <= 1'b0;
            clr_base_q <= '0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            ready_q    <= ready_d;
            occ_reg_q  <= occ_reg_d;
            occ_tag_q  <= occ_tag_d;
            set_reg_q  <= set_reg_d;
            set_tag_q  <= set_tag_d;
            set_val_q  <= set_val_d;
            clr_en_q   <= clr_en_d;
            clr_base_q <= clr_base_d;
            stall_q    <= stall_d;
        end
    end

    assign bus.dec_ready    = dec_ready;
    assign bus.rf_occ_reg   = occ_reg_q;
    assign bus.rf_occ_tag   = occ_tag_q;
    assign bus.rf_set_reg   = set_reg_q;
    assign bus.rf_set_tag   = set_tag_q;
    assign bus.rf_set_value = set_val_q;
    assign bus.rf_clr_en    = clr_en_q;
    assign bus.rf_clr_base  = clr_base_q;
    assign bus.sweeping     = (state_q == S_CLEAR);
    assign bus.stall_cnt    = stall_q;
endmodule

// File: tb/tb_reg_rename_ctrl.sv
// Bench for reg_rename_ctrl: directed vector table, corner sequences
// (flush mid-sweep, reset mid-sweep, stall saturation) and random traffic
// checked against a chunk-counting reference model.
module tb_reg_rename_ctrl;
    localparam int REG_COUNT = 32;
    localparam int CLR_CHUNK = 4;
    localparam int NCHUNK    = REG_COUNT / CLR_CHUNK;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    reg_rename_ctrl_if #(.REG_W(5), .ROB_W(4), .DATA_W(32)) bus ();

    reg_rename_ctrl #(
        .REG_COUNT(32), .REG_W(5), .ROB_W(4), .DATA_W(32), .CLR_CHUNK(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: sweep progress as a chunk counter.
    bit          m_sweep;
    int          m_chunk;
    logic [4:0]  m_occ, m_set, m_base;
    logic [3:0]  m_occt, m_sett;
    logic [31:0] m_setv;
    logic        m_clr;
    int          m_stall;
    logic        last_rdy;

    task automatic model_reset();
        m_sweep = 1; m_chunk = 0; m_occ = 0; m_occt = 0; m_set = 0; m_sett = 0;
        m_setv = 0; m_clr = 0; m_base = 0; m_stall = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".occ_reg"},  32'(bus.rf_occ_reg),  32'(m_occ));
        chk({tag, ".occ_tag"},  32'(bus.rf_occ_tag),  32'(m_occt));
        chk({tag, ".set_reg"},  32'(bus.rf_set_reg),  32'(m_set));
        chk({tag, ".set_tag"},  32'(bus.rf_set_tag),  32'(m_sett));
        chk({tag, ".set_val"},  bus.rf_set_value,     m_setv);
        chk({tag, ".clr_en"},   32'(bus.rf_clr_en),   32'(m_clr));
        chk({tag, ".clr_base"}, 32'(bus.rf_clr_base), 32'(m_base));
        chk({tag, ".sweeping"}, 32'(bus.sweeping),    32'(m_sweep));
        chk({tag, ".stall"},    32'(bus.stall_cnt),   32'(m_stall));
    endtask

    // Called with clk low; returns at the next negedge.
    task automatic step(input string tag, input logic fl, input logic dv, input logic [4:0] rd,
                        input logic [3:0] tg, input logic cv, input logic [4:0] crd,
                        input logic [3:0] ctg, input logic [31:0] cval);
        logic rdy;
        bus.flush_in = fl; bus.dec_valid = dv; bus.dec_rd = rd; bus.dec_tag = tg;
        bus.cmt_valid = cv; bus.cmt_rd = crd; bus.cmt_tag = ctg; bus.cmt_value = cval;
        #1;
        rdy = !m_sweep && !fl;
        last_rdy = bus.dec_ready;
        chk({tag, ".dec_ready"}, 32'(bus.dec_ready), 32'(rdy));
        @(posedge clk);
        if (dv && rdy && rd != 0) begin m_occ = rd; m_occt = tg; end
        else begin m_occ = 0; m_occt = 0; end
        if (cv && crd != 0) begin m_set = crd; m_sett = ctg; m_setv = cval; end
        else begin m_set = 0; m_sett = 0; m_setv = 0; end
        if (dv && !rdy && m_stall < 16'hFFFF) m_stall++;
        if (m_sweep) begin
            m_clr = 1;
            if (fl) begin m_base = 0; m_chunk = 1; end
            else begin m_base = 5'(m_chunk * CLR_CHUNK); m_chunk++; end
            if (m_chunk == NCHUNK) m_sweep = 0;
        end else begin
            m_clr = 0; m_base = 0;
            if (fl) begin m_sweep = 1; m_chunk = 0; end
        end
        #1;
        check_outputs(tag);
        @(negedge clk);
    endtask

    task automatic idle_step(input string tag);
        step(tag, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    typedef struct {
        logic fl, dv; logic [4:0] rd; logic [3:0] tg;
        logic cv; logic [4:0] crd; logic [3:0] ctg; logic [31:0] cval;
        logic e_rdy; logic [4:0] e_occ; logic [4:0] e_set;
        logic e_clr; logic [4:0] e_base; logic e_sw; logic [15:0] e_stall;
    } vec_t;

    function automatic vec_t mkv(logic fl, logic dv, logic [4:0] rd, logic [3:0] tg,
                                 logic cv, logic [4:0] crd, logic [3:0] ctg, logic [31:0] cval,
                                 logic e_rdy, logic [4:0] e_occ, logic [4:0] e_set,
                                 logic e_clr, logic [4:0] e_base, logic e_sw, logic [15:0] e_stall);
        vec_t v;
        v.fl = fl; v.dv = dv; v.rd = rd; v.tg = tg; v.cv = cv; v.crd = crd; v.ctg = ctg;
        v.cval = cval; v.e_rdy = e_rdy; v.e_occ = e_occ; v.e_set = e_set; v.e_clr = e_clr;
        v.e_base = e_base; v.e_sw = e_sw; v.e_stall = e_stall;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        int cnt;
        bit found;
        bus.flush_in = 0; bus.dec_valid = 0; bus.dec_rd = 0; bus.dec_tag = 0;
        bus.cmt_valid = 0; bus.cmt_rd = 0; bus.cmt_tag = 0; bus.cmt_value = 0;
        model_reset();

        // Initial sweep with dec_valid held, commit during CLEAR, renames, flush.
        for (int i = 0; i < 8; i++) begin
            if (i == 2)
                tbl.push_back(mkv(0, 1, 5, 3, 1, 7, 2, 32'hDEADBEEF, 0, 0, 7, 1, 5'(4*i), 1, 16'(i+1)));
            else
                tbl.push_back(mkv(0, 1, 5, 3, 0, 0, 0, 0, 0, 0, 0, 1, 5'(4*i), (i < 7), 16'(i+1)));
        end
        tbl.push_back(mkv(0, 1, 5, 3, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 8));
        tbl.push_back(mkv(0, 1, 0, 6, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 8));
        tbl.push_back(mkv(1, 1, 9, 1, 1, 3, 4, 32'h1234, 0, 0, 3, 0, 0, 1, 9));
        tbl.push_back(mkv(0, 0, 9, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 9));

        // Reset state
        #2;
        chk("rst.sweeping", 32'(bus.sweeping), 1);
        chk("rst.clr_en", 32'(bus.rf_clr_en), 0);
        chk("rst.dec_ready", 32'(bus.dec_ready), 0);
        chk("rst.stall", 32'(bus.stall_cnt), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1;

        foreach (tbl[i]) begin
            step($sformatf("vec%0d", i), tbl[i].fl, tbl[i].dv, tbl[i].rd, tbl[i].tg,
                 tbl[i].cv, tbl[i].crd, tbl[i].ctg, tbl[i].cval);
            chk($sformatf("vec%0d.t_rdy", i), 32'(last_rdy), 32'(tbl[i].e_rdy));
            chk($sformatf("vec%0d.t_occ", i), 32'(bus.rf_occ_reg), 32'(tbl[i].e_occ));
            chk($sformatf("vec%0d.t_set", i), 32'(bus.rf_set_reg), 32'(tbl[i].e_set));
            chk($sformatf("vec%0d.t_clr", i), 32'(bus.rf_clr_en), 32'(tbl[i].e_clr));
            chk($sformatf("vec%0d.t_base", i), 32'(bus.rf_clr_base), 32'(tbl[i].e_base));
            chk($sformatf("vec%0d.t_sw", i), 32'(bus.sweeping), 32'(tbl[i].e_sw));
            chk($sformatf("vec%0d.t_stall", i), 32'(bus.stall_cnt), 32'(tbl[i].e_stall));
            if (i == 2) chk("vec2.t_setval", bus.rf_set_value, 32'hDEADBEEF);
        end

        // Flush in mid-sweep once base 12 has been issued: restart at 0, 8 full cycles.
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (bus.rf_clr_en && bus.rf_clr_base == 12) found = 1;
            else idle_step("seekA");
        end
        chk("flushA.found", 32'(found), 1);
        step("flushA", 1, 1, 9, 2, 0, 0, 0, 0);
        chk("flushA.base0", 32'(bus.rf_clr_base), 0);
        cnt = 1;
        for (int i = 0; i < 20 && bus.sweeping; i++) begin
            idle_step("flushA.sw");
            if (bus.rf_clr_en) cnt++;
        end
        chk("flushA.len", 32'(cnt), 8);
        chk("flushA.last", 32'(bus.rf_clr_base), 28);

        // Reset mid-sweep at base 20.
        step("flushB", 1, 0, 0, 0, 0, 0, 0, 0);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (bus.rf_clr_en && bus.rf_clr_base == 20) found = 1;
            else step("seekB", 0, 1, 4, 4, 1, 3, 1, 32'h55);
        end
        chk("rstB.found", 32'(found), 1);
        #2 rst = 0;
        #1;
        model_reset();
        check_outputs("rstB");
        chk("rstB.dec_ready", 32'(bus.dec_ready), 0);
        @(negedge clk);
        rst = 1;
        idle_step("rstB.first");
        chk("rstB.base0", 32'(bus.rf_clr_base), 0);
        chk("rstB.stall0", 32'(bus.stall_cnt), 0);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            logic [4:0] rd, crd;
            rd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            crd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            step("rnd", ($urandom_range(0, 39) == 0), ($urandom_range(0, 9) < 7), rd,
                 4'($urandom), $urandom_range(0, 1) == 1, crd, 4'($urandom), $urandom);
        end

        // Stall counter saturation: flush held forces continuous stalls.
        bus.flush_in = 1; bus.dec_valid = 1; bus.cmt_valid = 0;
        repeat (65540) @(posedge clk);
        #1;
        chk("stall.sat", 32'(bus.stall_cnt), 32'h0000FFFF);
        chk("stall.sweep", 32'(bus.sweeping), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/reg_rename_ctrl.md
Name: reg_rename_ctrl

Overview:
- Sequences all tag/value updates into the register file: decoder rename (rd occupy), ROB commit (value write-back) and tag clearing.
- Tag clearing happens on reset and on misprediction flush.
- Clearing sweeps the tag array in fixed-size chunks over several cycles. The decoder is back-pressured for the whole sweep.
- Sits between decoder/ROB and the register file; drives the register file's occupy, set-value and clear ports.

Parameters:
- REG_COUNT, 32, number of architectural registers (power of 2).
- REG_W, 5, register index width, log2(REG_COUNT).
- ROB_W, 4, ROB tag width.
- DATA_W, 32, data width.
- CLR_CHUNK, 4, registers cleared per sweep cycle (power of 2, divides REG_COUNT).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush_in  in  1  misprediction flush pulse from ROB.
- dec_valid  in  1  decoder requests rename.
- dec_rd  in  REG_W  destination register.
- dec_tag  in  ROB_W  ROB tag allocated to rd.
- dec_ready  out  1  rename accepted this cycle.
- cmt_valid  in  1  ROB commit valid (never stalled).
- cmt_rd  in  REG_W  committed destination.
- cmt_tag  in  ROB_W  committing ROB entry tag.
- cmt_value  in  DATA_W  committed value.
- rf_occ_reg  out  REG_W  register to mark busy (0 = no-op).
- rf_occ_tag  out  ROB_W  tag for rf_occ_reg.
- rf_set_reg  out  REG_W  register to write (0 = no-op).
- rf_set_tag  out  ROB_W  tag of committing entry.
- rf_set_value  out  DATA_W  value to write.
- rf_clr_en  out  1  clear tags/busy of chunk this cycle.
- rf_clr_base  out  REG_W  first register of chunk; chunk = base .. base+CLR_CHUNK-1.
- sweeping  out  1  high while in CLEAR state.
- stall_cnt  out  16  saturating count of cycles with dec_valid && !dec_ready.

Behaviour:
- States: CLEAR, IDLE. State sets ready_q; dec_ready = ready_q && !flush_in.
- Reset (rst=0, async):
  - State = CLEAR, base = 0, ready_q = 0, stall_cnt = 0.
  - All rf_* outputs = 0, sweeping = 1.
- All rf_* outputs are registered: one-cycle latency from input sample to output.
- CLEAR state:
  - Each cycle drive rf_clr_en = 1 and rf_clr_base = base on the next edge, then base += CLR_CHUNK.
  - After the chunk with base = REG_COUNT - CLR_CHUNK is issued, go to IDLE. A sweep is REG_COUNT/CLR_CHUNK cycles (8 at default).
  - ready_q = 0 throughout.
- IDLE state: ready_q = 1, rf_clr_en = 0.
- Rename: on a cycle with dec_valid && dec_ready && dec_rd != 0, next cycle rf_occ_reg = dec_rd, rf_occ_tag = dec_tag. Otherwise rf_occ_reg = 0, rf_occ_tag = 0.
- dec_rd == 0 is accepted (dec_ready honoured) but produces no occupy.
- Commit is processed in every state, including CLEAR. On cmt_valid && cmt_rd != 0, next cycle rf_set_reg/tag/value = cmt inputs. Otherwise rf_set_reg = 0 and tag/value hold 0.
- Flush:
  - flush_in in IDLE: dec_ready is forced low that cycle, so the same-cycle rename is dropped. Next state CLEAR, base = 0.
  - flush_in during CLEAR: restart the sweep at base = 0.
  - Commit in the flush cycle is still forwarded.
- Simultaneous rf_set and rf_clr on the same register in one cycle: the value is written, and the tag/busy ends cleared. This is a register-file requirement; the controller drives both.
- Occupy and set on the same register in one cycle: occupy wins on the tag. This register-file rule is unchanged; the controller passes both through.
- stall_cnt increments when dec_valid && !dec_ready and saturates at 16'hFFFF.
- Reset asserted mid-sweep or mid-operation: immediate return to reset values, and the sweep restarts from 0.

Test Plan:
- Release rst; hold dec_valid = 1 -> rf_clr_en high for 8 cycles with base 0,4,...,28; sweeping falls after base = 28; dec_ready rises the following cycle; stall_cnt = 8.
- IDLE, dec_valid = 1, dec_rd = 5, dec_tag = 3 -> next cycle rf_occ_reg = 5, rf_occ_tag = 3; dec_rd = 0 -> rf_occ_reg = 0 with dec_ready = 1.
- cmt_valid, cmt_rd = 7, cmt_tag = 2, value = 32'hDEADBEEF during CLEAR -> next cycle rf_set_reg = 7, rf_set_value = 32'hDEADBEEF, rf_clr_en also 1.
- flush_in with dec_valid (rd = 9) in the same cycle -> dec_ready = 0, no occupy for 9, 8-cycle sweep from base 0.
- flush_in again at sweep base = 12 -> next rf_clr_base = 0, full 8 further cycles.
- rst pulsed low at sweep base = 20 -> outputs zero immediately; after release, sweep restarts at 0 and stall_cnt = 0.
